mem_ctrl_ram: RTL
=================

// Module: mem_ctrl_ram
// PURPOSE
//   Parametrised single-port RAM behind a valid/ready request/response handshake. Successor to the
//   8-bit tri-state memory: separate read/write data buses, byte-lane writes, programmable wait states,
//   out-of-range error reporting. Sits between the CPU load/store unit and on-chip storage; one
//   outstanding request at a time.
// PARAMETERS
//   DATA_W       8      data width in bits; must be a multiple of 8
//   ADDR_W       16     address width; word-addressed
//   DEPTH        65536  implemented words, <= 2**ADDR_W; addresses >= DEPTH are out of range
//   WAIT_STATES  0      extra cycles between accept and response, 0..15
//   BE_W         DATA_W/8  byte-enable width (derived, do not override)
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous reset, active high
//   req_valid  in   1        request present
//   req_ready  out  1        block can accept a request this cycle
//   req_write  in   1        1 = write, 0 = read
//   req_addr   in   ADDR_W   word address
//   req_wdata  in   DATA_W   write data
//   req_be     in   BE_W     byte enables for writes; ignored on reads
//   rsp_valid  out  1        response present; held until rsp_ready
//   rsp_ready  in   1        consumer takes the response
//   rsp_rdata  out  DATA_W   read data; 0 for writes and errors
//   rsp_err    out  1        request address was out of range
// BEHAVIOUR
//   - Reset (async assert, released on clk edge): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0,
//     rsp_err=0, wait counter 0. RAM contents are NOT reset.
//   - FSM: IDLE -> (accept) -> WAIT if WAIT_STATES>0 else RESP; WAIT counts WAIT_STATES cycles -> RESP;
//     RESP -> (rsp_ready) -> IDLE.
//   - Accept = req_valid & req_ready at a rising edge; req_ready=1 only in IDLE (no pipelining).
//   - Write committed at the accepting edge: each lane i with req_be[i]=1 gets req_wdata[8i+7:8i];
//     other lanes keep their value. be=0 is a legal no-op and still gets a response.
//   - Read data sampled from the array at the accepting edge into a response register.
//   - Latency: rsp_valid rises 1+WAIT_STATES cycles after the accepting edge.
//   - rsp_valid, rsp_rdata and rsp_err stay stable while rsp_valid=1 & rsp_ready=0.
//   - Response consumed at an edge with rsp_valid & rsp_ready; next cycle IDLE, req_ready=1. A new
//     request cannot be accepted in the same cycle the response is consumed.
//   - rsp_ready asserted outside RESP is ignored.
//   - Out of range (req_addr >= DEPTH): no array access, write dropped, rsp_rdata=0, rsp_err=1,
//     same latency as a normal request.
//   - Read and write to the same address are serialised by the handshake; read-after-write returns
//     the new data.
//   - Reset mid-operation: in-flight response discarded, FSM to IDLE. A write already accepted stays
//     committed.
//   - Wait counter width: 4 bits; WAIT_STATES > 15 is a parameter error (elaboration assertion).
// STRUCTURE
//   - mem_pkg: state enum {IDLE, WAIT, RESP}, WAIT_CNT_W=4, byte-lane helper constant LANE_W=8.
//   - Sub-module mem_ram_array: DEPTH x DATA_W storage with per-byte write enables and synchronous
//     registered read. Handshake FSM, counter and range check live in mem_ctrl_ram.
// TESTING
//   1 Reset mid-WAIT (WAIT_STATES=3): rst pulse 2 cycles after accept -> rsp_valid=0, req_ready=1;
//     prior write retained.
//   2 Write/readback: DATA_W=32, WAIT_STATES=0. Write addr 0x0010 data 0xDEADBEEF be=4'hF ->
//     rsp_valid one cycle later, err=0. Read 0x0010 -> rsp_rdata=0xDEADBEEF.
//   3 Byte lanes: after test 2, write 0x0010 data 0x11223344 be=4'b0101 -> read gives 0xDE22BE44.
//   4 Wait states: WAIT_STATES=3. Read accepted at edge N -> rsp_valid first high at edge N+4;
//     req_ready=0 from N+1 until the cycle after the response is consumed.
//   5 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable throughout;
//     req_valid held high is not accepted until IDLE.
//   6 Out of range: DEPTH=1024. Write 0x0400 data 0xFFFFFFFF -> rsp_err=1; read 0x0400 -> rdata=0,
//     err=1; read 0x03FF unaffected.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type and sizing constants for the request/response RAM.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int WAIT_CNT_W = 4;
  localparam int LANE_W = 8;
endpackage

// File: rtl/mem_ram_array.sv
// mem_ram_array: DEPTH x DATA_W storage with per-byte write enables and a registered read port.
module mem_ram_array
  import mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 65536,
  localparam int BE_W  = DATA_W / LANE_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (en) q <= mem[addr];
    for (int i = 0; i < BE_W; i++)
      if (we && be[i]) mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
  end
endmodule

// File: rtl/mem_ctrl_ram.sv
// mem_ctrl_ram: single-port RAM behind a one-outstanding valid/ready handshake
// with byte-lane writes, programmable wait states and out-of-range error reporting.
module mem_ctrl_ram
  import mem_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 65536,
  parameter int WAIT_STATES = 0,
  localparam int BE_W       = DATA_W / LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

  if (WAIT_STATES < 0 || WAIT_STATES > 15) $error("WAIT_STATES must be 0..15");
  if (DATA_W % LANE_W != 0) $error("DATA_W must be a multiple of 8");
  if (DEPTH < 1 || AW > ADDR_W) $error("DEPTH must fit in the address space");

  state_t                state;
  logic [WAIT_CNT_W-1:0] cnt;
  logic                  rd_ok;
  logic                  accept;
  logic                  in_range;
  logic [DATA_W-1:0]     ram_q;

  assign accept   = req_valid & req_ready;
  assign in_range = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);
  // the array's read register holds its value until the next in-range access,
  // so it can drive the response directly; writes and errors are masked to 0
  assign rsp_rdata = rd_ok ? ram_q : '0;

  mem_ram_array #(.DATA_W(DATA_W), .ADDR_W(AW), .DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .en    (accept & in_range),
    .we    (accept & in_range & req_write),
    .addr  (req_addr[AW-1:0]),
    .wdata (req_wdata),
    .be    (req_be),
    .q     (ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rd_ok     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          rsp_err   <= !in_range;
          rd_ok     <= in_range & !req_write;
          if (WAIT_STATES == 0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            state <= WAIT;
            cnt   <= WAIT_CNT_W'(WAIT_STATES - 1);
          end
        end
        WAIT: if (cnt == '0) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
        end else cnt <= cnt - 1'b1;
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
